// File: rtl/synth_pkg.sv
// Shared types and width helpers for the audio mixing datapath.
package synth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUTPUT
   } mixer_state_t;

   // Accumulator width that holds n full-scale products without overflow.
   function automatic int acc_width(input int data_w, input int gain_w, input int n);
      return data_w + gain_w + 1 + $clog2(n);
   endfunction

   function automatic logic signed [63:0] SAT_MAX(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] SAT_MIN(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

endpackage

// File: rtl/mix_saturate.sv
// Drops GAIN_W fractional bits from a signed accumulator (floor) and clamps
// the result to a signed DATA_W sample, flagging when clamping occurred.
module mix_saturate
   import synth_pkg::*;
#(
   parameter int ACC_W  = 36,
   parameter int DATA_W = 16,
   parameter int GAIN_W = 16
) (
   input  logic signed [ACC_W-1:0]  acc,
   output logic signed [DATA_W-1:0] sample,
   output logic                     clip
);

   localparam int SH_W = ACC_W - GAIN_W;
   localparam logic signed [SH_W-1:0] MAX_V = SH_W'(SAT_MAX(DATA_W));
   localparam logic signed [SH_W-1:0] MIN_V = SH_W'(SAT_MIN(DATA_W));

   logic signed [SH_W-1:0] shifted;

   // Taking the upper bits is an arithmetic shift right that rounds toward -inf.
   assign shifted = acc[ACC_W-1:GAIN_W];

   // NOTE: every output gets a default before the if chain, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      sample = shifted[DATA_W-1:0];
      clip   = 1'b0;
      if (shifted > MAX_V) begin
         sample = MAX_V[DATA_W-1:0];
         clip   = 1'b1;
      end else if (shifted < MIN_V) begin
         sample = MIN_V[DATA_W-1:0];
         clip   = 1'b1;
      end
   end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed N-voice mixer: snapshot on strobe, one multiply-accumulate
// per clock, then a floor-shifted, saturated output sample with clip flag.
module voice_mixer
   import synth_pkg::*;
#(
   parameter int N_VOICES = 8,
   parameter int DATA_W   = 16,
   parameter int GAIN_W   = 16
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         sample_strobe,
   input  logic [N_VOICES*DATA_W-1:0]   voice_in,
   input  logic [N_VOICES*GAIN_W-1:0]   gain,
   input  logic [N_VOICES-1:0]          mute,
   output logic [DATA_W-1:0]            mix_out,
   output logic                         out_valid,
   output logic                         clip,
   output logic                         busy,
   output logic                         overrun
);

   localparam int ACC_W  = acc_width(DATA_W, GAIN_W, N_VOICES);
   localparam int PROD_W = DATA_W + GAIN_W + 1;
   localparam int IDX_W  = $clog2(N_VOICES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);

   mixer_state_t state_q, state_d;

   logic signed [ACC_W-1:0]      acc_q, acc_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [N_VOICES*DATA_W-1:0]   voice_q, voice_d;
   logic [N_VOICES*GAIN_W-1:0]   gain_q, gain_d;
   logic [N_VOICES-1:0]          mute_q, mute_d;
   logic signed [DATA_W-1:0]     mix_out_q, mix_out_d;
   logic                         clip_q, clip_d;
   logic                         out_valid_q, out_valid_d;
   logic                         overrun_q, overrun_d;

   logic signed [DATA_W-1:0]     voice_sel;
   logic [GAIN_W-1:0]            gain_sel;
   logic signed [PROD_W-1:0]     voice_ext;
   logic signed [PROD_W-1:0]     gain_ext;
   logic signed [PROD_W-1:0]     product;
   logic signed [DATA_W-1:0]     sat_sample;
   logic                         sat_clip;

   // Single shared multiplier fed from the snapshot by the voice index.
   always_comb begin
      voice_sel = voice_q[idx_q*DATA_W +: DATA_W];
      gain_sel  = gain_q[idx_q*GAIN_W +: GAIN_W];
      voice_ext = PROD_W'(voice_sel);
      gain_ext  = PROD_W'(gain_sel);
      product   = mute_q[idx_q] ? '0 : voice_ext * gain_ext;
   end

   mix_saturate #(
      .ACC_W  (ACC_W),
      .DATA_W (DATA_W),
      .GAIN_W (GAIN_W)
   ) u_mix_saturate (
      .acc    (acc_q),
      .sample (sat_sample),
      .clip   (sat_clip)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      voice_d     = voice_q;
      gain_d      = gain_q;
      mute_d      = mute_q;
      mix_out_d   = mix_out_q;
      clip_d      = clip_q;
      out_valid_d = 1'b0;
      overrun_d   = sample_strobe && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (sample_strobe) begin
               voice_d = voice_in;
               gain_d  = gain;
               mute_d  = mute;
               acc_d   = '0;
               idx_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = acc_q + ACC_W'(product);
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = OUTPUT;
            end
         end
         OUTPUT: begin
            mix_out_d   = sat_sample;
            clip_d      = sat_clip;
            out_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         idx_q       <= '0;
         mix_out_q   <= '0;
         clip_q      <= 1'b0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         mix_out_q   <= mix_out_d;
         clip_q      <= clip_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // NOTE: the snapshot is plain datapath storage; it is always written before
   // being read, so it carries no reset.
   always_ff @(posedge Clk) begin
      voice_q <= voice_d;
      gain_q  <= gain_d;
      mute_q  <= mute_d;
   end

   assign mix_out   = mix_out_q;
   assign clip      = clip_q;
   assign out_valid = out_valid_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule
